anchor_sweep_ctrl: RTL and testbench

Runtime-configurable scheduler that sequences one raster sweep of 2D anchor points (row-major, width first) over a feature map. Anchors are handed to the downstream window/address generator through a valid/ready handshake. A start/busy/done handshake with the layer controller frames each sweep, and pause/abort inputs provide stall and teardown. It replaces fixed-parameter anchor stepping so that one instance serves every conv/pool layer: geometry and strides are latched per sweep.

---
 rtl/anchor_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_anchor_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/anchor_sweep_ctrl.sv
// anchor_sweep_ctrl: walks one row-major raster of anchor points over a
// feature map. Geometry and strides are latched at start, so a single
// instance can serve every layer. Anchors are handed downstream through a
// valid/ready handshake, and each sweep is framed by start/busy/done.
module anchor_sweep_ctrl #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_stride_h,
  input  logic [DIM_W-1:0] cfg_stride_w,
  input  logic             pause,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIM_W-1:0] row, col;
  logic [DIM_W-1:0] h, w, sh, sw;
  logic             cfg_err_q;

  logic             cfg_bad, accept, col_fit, row_fit;
  logic [DIM_W:0]   col_sum, row_sum, w_max, h_max;

  // One extra bit on the sums keeps a near-max coordinate plus stride from
  // wrapping back into range. Height and width are never 0 in RUN, so the
  // limits cannot underflow while they are in use.
  assign col_sum = {1'b0, col} + {1'b0, sw};
  assign row_sum = {1'b0, row} + {1'b0, sh};
  assign w_max   = {1'b0, w} - {{DIM_W{1'b0}}, 1'b1};
  assign h_max   = {1'b0, h} - {{DIM_W{1'b0}}, 1'b1};
  assign col_fit = (col_sum <= w_max);
  assign row_fit = (row_sum <= h_max);

  assign cfg_bad = (cfg_height == '0) | (cfg_width == '0) |
                   (cfg_stride_h == '0) | (cfg_stride_w == '0);

  // pause has a combinational path to valid, so a stall takes effect in the
  // same cycle it is raised.
  assign out_valid = (state == RUN) & ~pause;
  assign accept    = out_valid & out_ready;
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = (state == RUN) & ~col_fit & ~row_fit;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign cfg_err   = cfg_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !cfg_bad) state_nxt = RUN;
      RUN:     if (accept && !col_fit && !row_fit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Config latch, anchor position and the cfg_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      h         <= '0;
      w         <= '0;
      sh        <= '0;
      sw        <= '0;
      cfg_err_q <= 1'b0;
    end else if (abort) begin
      row       <= '0;
      col       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              h   <= cfg_height;
              w   <= cfg_width;
              sh  <= cfg_stride_h;
              sw  <= cfg_stride_w;
              row <= '0;
              col <= '0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (col_fit) begin
              col <= col_sum[DIM_W-1:0];
            end else begin
              col <= '0;
              // Clearing the row on the final accept leaves the coordinate
              // outputs at zero once the sweep has finished.
              row <= row_fit ? row_sum[DIM_W-1:0] : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anchor_sweep_ctrl.sv
// Self-checking bench for anchor_sweep_ctrl. The expected anchor sequence
// for every sweep comes from plain nested loops over the configured
// geometry. Handshake stalls and pauses are randomized.
module tb_anchor_sweep_ctrl;
  localparam int DIM_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] cfg_height = '0, cfg_width = '0;
  logic [DIM_W-1:0] cfg_stride_h = '0, cfg_stride_w = '0;
  logic             pause = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic             out_valid, out_last, busy, done, cfg_err;
  logic [DIM_W-1:0] out_row, out_col;

  int tests = 0;
  int fails = 0;

  anchor_sweep_ctrl #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_height(cfg_height), .cfg_width(cfg_width),
    .cfg_stride_h(cfg_stride_h), .cfg_stride_w(cfg_stride_w),
    .pause(pause), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({out_valid, busy, done, cfg_err, out_last} !== 5'b0 ||
        out_row !== '0 || out_col !== '0) begin
      fails++;
      $display("FAIL %s: valid=%0b busy=%0b done=%0b err=%0b last=%0b row=%0d col=%0d, required all 0",
               name, out_valid, busy, done, cfg_err, out_last, out_row, out_col);
    end
  endtask

  // One full sweep against the reference list. rnd randomizes out_ready and
  // pause; poke toggles start and scrambles cfg while running and in the
  // done cycle, which must have no effect.
  task automatic run_sweep(input int hh, input int ww, input int sh, input int sw,
                           input bit rnd, input bit poke);
    int q_r[$], q_c[$];
    int budget, n_acc, n_exp;
    for (int r = 0; r < hh; r += sh)
      for (int c = 0; c < ww; c += sw) begin
        q_r.push_back(r);
        q_c.push_back(c);
      end
    n_exp = q_r.size();
    n_acc = 0;
    cfg_height = hh[DIM_W-1:0]; cfg_width = ww[DIM_W-1:0];
    cfg_stride_h = sh[DIM_W-1:0]; cfg_stride_w = sw[DIM_W-1:0];
    pause = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    while (q_r.size() > 0 && budget < 2000) begin
      if (rnd) begin
        pause = ($urandom_range(0, 4) == 0);
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        pause = 1'b0; out_ready = 1'b1;
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        cfg_height = 16'($urandom_range(0, 20)); cfg_width = 16'($urandom_range(0, 20));
        cfg_stride_h = 16'($urandom_range(0, 3)); cfg_stride_w = 16'($urandom_range(0, 3));
      end
      @(negedge clk);
      tests++;
      if (out_valid !== !pause || busy !== 1'b1) begin
        fails++;
        $display("FAIL sweep_valid: valid=%0b busy=%0b, required valid=%0b busy=1",
                 out_valid, busy, !pause);
      end
      if (out_valid) begin
        tests++;
        if (out_row !== q_r[0] || out_col !== q_c[0] || out_last !== (q_r.size() == 1)) begin
          fails++;
          $display("FAIL sweep_anchor: got (%0d,%0d) last=%0b, required (%0d,%0d) last=%0b",
                   out_row, out_col, out_last, q_r[0], q_c[0], q_r.size() == 1);
        end
        if (out_ready) begin
          void'(q_r.pop_front());
          void'(q_c.pop_front());
          n_acc++;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    tests++;
    if (n_acc != n_exp) begin
      fails++;
      $display("FAIL sweep_count: accepted %0d, required %0d", n_acc, n_exp);
    end
    start = poke;
    pause = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sweep_done: done=%0b busy=%0b valid=%0b, required 1 0 0", done, busy, out_valid);
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL sweep_after_done: done=%0b busy=%0b, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    #3 check_idle_outputs("reset_hold");
    #9 rst_n = 1'b1;
    @(negedge clk) check_idle_outputs("reset_release");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_sweep(4, 4, 1, 1, 1'b0, 1'b0);
    run_sweep(5, 7, 2, 3, 1'b0, 1'b0);
    run_sweep(2, 3, 5, 9, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_sweep(3, 3, 1, 1, 1'b1, 1'b0);
    run_sweep(6, 5, 2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < 4; i++) begin
      cfg_height = 3; cfg_width = 3; cfg_stride_h = 1; cfg_stride_w = 1;
      case (i)
        0: cfg_width = 0;
        1: cfg_height = 0;
        2: cfg_stride_h = 0;
        default: cfg_stride_w = 0;
      endcase
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      tests++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err_pulse[%0d]: err=%0b busy=%0b valid=%0b, required 1 0 0",
                 i, cfg_err, busy, out_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err_clear[%0d]: err=%0b busy=%0b, required 0 0", i, cfg_err, busy);
      end
      @(posedge clk); #1;
    end
    run_sweep(2, 2, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int budget;
    cfg_height = 4; cfg_width = 4; cfg_stride_h = 1; cfg_stride_w = 1;
    out_ready = 1'b1; pause = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    @(negedge clk);
    while (!(out_valid && out_row == 1 && out_col == 2) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    tests++;
    if (budget >= 50) begin
      fails++;
      $display("FAIL abort_reach: anchor (1,2) not presented within budget");
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    @(negedge clk) check_idle_outputs("abort_next");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done: done=%0b busy=%0b, required 0 0", done, busy);
      end
    end
    @(posedge clk); #1;
    run_sweep(2, 3, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_sweep(3, 4, 1, 2, 1'b0, 1'b1);
    run_sweep(4, 4, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_sweep($urandom_range(1, 9), $urandom_range(1, 9),
                $urandom_range(1, 10), $urandom_range(1, 10), 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_async_reset();
    cfg_height = 5; cfg_width = 5; cfg_stride_h = 1; cfg_stride_w = 1;
    out_ready = 1'b1; pause = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    #3 rst_n = 1'b1;
    @(negedge clk) check_idle_outputs("async_reset_release");
    @(posedge clk); #1;
    run_sweep(3, 3, 1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cfg_err();
    test_abort();
    test_start_ignored();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
